// File: rtl/fnd_counter_display.sv
// ---------------------------------------------------------------------------
// fnd_counter_display
//
// Purpose:
//   Board-top block that combines a prescaled modulo up/down counter with a
//   4-digit multiplexed 7-segment (FND) driver. It includes decimal digit
//   extraction, optional leading-zero blanking and a "paused" indicator. The
//   indicator lights the ones-digit decimal point while run is low.
//
// Parameters:
//   MAX_COUNT  terminal count value (1..9999)
//   TICK_DIV   clock cycles per count step (>= 2)
//   SCAN_DIV   clock cycles each digit stays selected (>= 1)
//   BLANK_LZ   1 = blank leading zero digits (ones digit is never blanked)
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   run        in   1   1 = prescaler/counter advance, 0 = paused
//   up_dn      in   1   1 = count up, 0 = count down
//   clear      in   1   synchronous clear of counter and prescaler
//   count_out  out  14  current count, binary
//   wrap       out  1   one-cycle pulse, coincident with the wrapped count
//   fndFont    out  8   segments, active-low; bit7 = dp, bits6:0 = g..a
//   fndCom     out  4   digit select, active-low one-hot; bit0 = ones digit
// ---------------------------------------------------------------------------
module fnd_counter_display #(
    parameter int MAX_COUNT = 9999,
    parameter int TICK_DIV  = 100000,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_LZ  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        up_dn,
    input  logic        clear,
    output logic [13:0] count_out,
    output logic        wrap,
    output logic [7:0]  fndFont,
    output logic [3:0]  fndCom
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
    localparam logic [13:0]   C_MAX  = 14'(MAX_COUNT);

    // Active-low segment pattern for one decimal digit, dp off.
    function automatic logic [7:0] fn_font(input logic [3:0] d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    logic [PW-1:0] r_presc;
    logic [13:0]   r_count;
    logic          r_wrap;
    logic [SW-1:0] r_scan;
    logic [1:0]    r_idx;
    logic [3:0]    r_com;
    logic [7:0]    r_font;

    logic          w_tick;
    logic [3:0]    w_d0;
    logic [3:0]    w_d1;
    logic [3:0]    w_d2;
    logic [3:0]    w_d3;
    logic          w_blank1;
    logic          w_blank2;
    logic          w_blank3;
    logic [7:0]    w_seg;

    // tick is only meaningful while running; the prescaler is frozen otherwise.
    assign w_tick = run && (r_presc == P_LAST);

    // ---- prescaler and modulo counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (clear) begin
            r_presc <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_tick) begin
            r_presc <= '0;
            if (up_dn) begin
                if (r_count == C_MAX) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count + 14'd1;
                    r_wrap  <= 1'b0;
                end
            end else begin
                if (r_count == 14'd0) begin
                    r_count <= C_MAX;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count - 14'd1;
                    r_wrap  <= 1'b0;
                end
            end
        end else begin
            if (run) begin
                r_presc <= r_presc + PW'(1);
            end
            r_wrap <= 1'b0;
        end
    end

    // ---- digit scan timer, free-running regardless of run/clear ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= '0;
            r_idx  <= 2'd0;
        end else if (r_scan == S_LAST) begin
            r_scan <= '0;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_scan <= r_scan + SW'(1);
        end
    end

    // ---- decimal digits and blanking from the registered count ----
    assign w_d0 = 4'(r_count % 14'd10);
    assign w_d1 = 4'((r_count / 14'd10) % 14'd10);
    assign w_d2 = 4'((r_count / 14'd100) % 14'd10);
    assign w_d3 = 4'(r_count / 14'd1000);

    // A digit is a leading zero only if it and every higher digit are zero.
    assign w_blank3 = (BLANK_LZ != 0) && (w_d3 == 4'd0);
    assign w_blank2 = w_blank3 && (w_d2 == 4'd0);
    assign w_blank1 = w_blank2 && (w_d1 == 4'd0);

    always_comb begin
        w_seg = 8'hFF;
        case (r_idx)
            2'd0:    w_seg = fn_font(w_d0);
            2'd1:    w_seg = w_blank1 ? 8'hFF : fn_font(w_d1);
            2'd2:    w_seg = w_blank2 ? 8'hFF : fn_font(w_d2);
            default: w_seg = w_blank3 ? 8'hFF : fn_font(w_d3);
        endcase
        // Paused indicator: ones-digit decimal point lit.
        if (!run && (r_idx == 2'd0)) begin
            w_seg[7] = 1'b0;
        end
    end

    // ---- registered display outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_com  <= 4'b1110;
            r_font <= 8'hC0;
        end else begin
            r_com  <= ~(4'b0001 << r_idx);
            r_font <= w_seg;
        end
    end

    assign count_out = r_count;
    assign wrap      = r_wrap;
    assign fndCom    = r_com;
    assign fndFont   = r_font;

endmodule

// File: tb/tb_fnd_counter_display.sv
// ---------------------------------------------------------------------------
// tb_fnd_counter_display
//
// Purpose:
//   Directed bench for fnd_counter_display. Three instances share the same
//   stimulus: dut_a (MAX_COUNT=12), dut_b (MAX_COUNT=9999) and dut_c
//   (MAX_COUNT=9999, no leading-zero blanking). All use TICK_DIV=4 and
//   SCAN_DIV=2. Expected values go into a scoreboard queue as each step is
//   driven, and they are popped and compared once the step's clock edge
//   has passed. k counts clock edges since reset release.
// ---------------------------------------------------------------------------
module tb_fnd_counter_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        up_dn;
    logic        clear;

    logic [13:0] cnt_a, cnt_b, cnt_c;
    logic        wrap_a, wrap_b, wrap_c;
    logic [7:0]  font_a, font_b, font_c;
    logic [3:0]  com_a, com_b, com_c;

    always #5 clk = ~clk;

    fnd_counter_display #(.MAX_COUNT(12), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)) dut_a (
        .clk(clk), .reset(reset), .run(run), .up_dn(up_dn), .clear(clear),
        .count_out(cnt_a), .wrap(wrap_a), .fndFont(font_a), .fndCom(com_a));

    fnd_counter_display #(.MAX_COUNT(9999), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)) dut_b (
        .clk(clk), .reset(reset), .run(run), .up_dn(up_dn), .clear(clear),
        .count_out(cnt_b), .wrap(wrap_b), .fndFont(font_b), .fndCom(com_b));

    fnd_counter_display #(.MAX_COUNT(9999), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(0)) dut_c (
        .clk(clk), .reset(reset), .run(run), .up_dn(up_dn), .clear(clear),
        .count_out(cnt_c), .wrap(wrap_c), .fndFont(font_c), .fndCom(com_c));

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;

    logic [3:0] com_tbl[4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] f1204[4]    = '{8'h99, 8'hC0, 8'hA4, 8'hF9};

    task automatic push(input string t, input logic [15:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty k=%0d obs=%0h", k, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s k=%0d obs=%0h exp=%0h", e.tag, k, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int n);
        while (k < n) step();
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b1;
        up_dn = 1'b1;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        k = 0;

        // Reset state on every instance.
        push("rst_cnt_a", 16'd0);   chk(16'(cnt_a));
        push("rst_wrap_a", 16'd0);  chk(16'(wrap_a));
        push("rst_com_a", 16'hE);   chk(16'(com_a));
        push("rst_font_a", 16'hC0); chk(16'(font_a));
        push("rst_cnt_b", 16'd0);   chk(16'(cnt_b));
        push("rst_wrap_b", 16'd0);  chk(16'(wrap_b));
        push("rst_com_b", 16'hE);   chk(16'(com_b));
        push("rst_font_b", 16'hC0); chk(16'(font_b));
        push("rst_cnt_c", 16'd0);   chk(16'(cnt_c));
        push("rst_wrap_c", 16'd0);  chk(16'(wrap_c));
        push("rst_com_c", 16'hE);   chk(16'(com_c));
        push("rst_font_c", 16'hC0); chk(16'(font_c));

        reset = 1'b0;

        // Count up: one step every 4 edges; dut_a wraps 12 -> 0 at edge 52.
        for (int i = 1; i <= 52; i++) begin
            push("up_cnt_a", 16'((i / 4) % 13));
            push("up_wrap_a", 16'(i == 52));
            push("up_cnt_b", 16'(i / 4));
            push("up_wrap_b", 16'd0);
            step();
            chk(16'(cnt_a));
            chk(16'(wrap_a));
            chk(16'(cnt_b));
            chk(16'(wrap_b));
        end

        // Direction change: next tick (edge 56) takes dut_a 0 -> 12 with wrap.
        up_dn = 1'b0;
        for (int i = 53; i <= 57; i++) begin
            push("dn_cnt_a", (i < 56) ? 16'd0 : 16'd12);
            push("dn_wrap_a", 16'(i == 56));
            push("dn_cnt_b", (i < 56) ? 16'd13 : 16'd12);
            push("dn_wrap_b", 16'd0);
            step();
            chk(16'(cnt_a));
            chk(16'(wrap_a));
            chk(16'(cnt_b));
            chk(16'(wrap_b));
        end

        // Count down to 5; edge 88 is a tick edge, clear must win over it.
        run_to(86);
        push("pre_clr_cnt_a", 16'd5);
        push("pre_clr_cnt_b", 16'd5);
        step();
        chk(16'(cnt_a));
        chk(16'(cnt_b));

        clear = 1'b1;
        up_dn = 1'b1;
        push("clr_cnt_b", 16'd0);
        push("clr_wrap_b", 16'd0);
        push("clr_cnt_a", 16'd0);
        step();
        chk(16'(cnt_b));
        chk(16'(wrap_b));
        chk(16'(cnt_a));
        clear = 1'b0;

        // Prescaler restarted: next increment exactly 4 edges after clear.
        for (int i = 89; i <= 92; i++) begin
            push("post_clr_cnt_b", (i < 92) ? 16'd0 : 16'd1);
            step();
            chk(16'(cnt_b));
        end

        // Reach 1204 on dut_b, then watch one full scan of four digits.
        run_to(4903);
        push("cnt_1204", 16'd1204);
        step();
        chk(16'(cnt_b));
        for (int i = 4905; i <= 4912; i++) begin
            push("scan_com", 16'(com_tbl[(i - 4905) / 2]));
            push("scan_font", 16'(f1204[(i - 4905) / 2]));
            step();
            chk(16'(com_b));
            chk(16'(font_b));
        end

        // Clear, count to 7, then pause.
        clear = 1'b1;
        push("clr2_cnt_b", 16'd0);
        step();
        chk(16'(cnt_b));
        clear = 1'b0;
        run_to(4940);
        push("cnt_7", 16'd7);
        step();
        chk(16'(cnt_b));

        run = 1'b0;
        for (int i = 4942; i <= 4957; i++) begin
            int idx;
            idx = ((i - 1) / 2) % 4;
            push("pause_cnt_b", 16'd7);
            push("pause_wrap_b", 16'd0);
            push("pause_com_b", 16'(com_tbl[idx]));
            push("pause_font_b", (idx == 0) ? 16'h78 : 16'hFF);
            push("pause_font_c", (idx == 0) ? 16'h78 : 16'hC0);
            step();
            chk(16'(cnt_b));
            chk(16'(wrap_b));
            chk(16'(com_b));
            chk(16'(font_b));
            chk(16'(font_c));
        end
        push("pause_cnt_a", 16'd7);
        chk(16'(cnt_a));

        // Resume; at edge 5077 count is 37 and the scan index is 2.
        run = 1'b1;
        run_to(5076);
        push("cnt_37", 16'd37);
        push("com_idx2", 16'hB);
        step();
        chk(16'(cnt_b));
        chk(16'(com_b));

        reset = 1'b1;
        push("mid_rst_cnt_b", 16'd0);
        push("mid_rst_wrap_b", 16'd0);
        push("mid_rst_com_b", 16'hE);
        push("mid_rst_font_b", 16'hC0);
        push("mid_rst_cnt_a", 16'd0);
        step();
        chk(16'(cnt_b));
        chk(16'(wrap_b));
        chk(16'(com_b));
        chk(16'(font_b));
        chk(16'(cnt_a));
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_counter_display.md
Name: fnd_counter_display

Overview:
- Parametrised successor of the single-digit 0–9 counter-plus-display top.
- Combines a prescaled modulo up/down counter (run, clear and direction controls) with a 4-digit multiplexed 7-segment driver.
- Decimal digit extraction, optional leading-zero blanking and a paused indicator are built in.
- Sits at board top level, directly driving the FND pins.

Parameters:
- MAX_COUNT, 9999: terminal count value; legal range 1..9999.
- TICK_DIV, 100000: clock cycles per count step; must be ≥ 2.
- SCAN_DIV, 1000: clock cycles each digit stays selected; must be ≥ 1.
- BLANK_LZ, 1: 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- run  input  1  1 = prescaler and counter advance; 0 = frozen (paused).
- up_dn  input  1  1 = count up, 0 = count down.
- clear  input  1  synchronous clear of counter and prescaler.
- count_out  output  14  current count, binary.
- wrap  output  1  one-cycle pulse when the counter wraps.
- fndFont  output  8  segments, active-low; bit7 = dp, bits6:0 = g..a.
- fndCom  output  4  digit select, active-low one-hot; bit0 = ones digit.

Behaviour:
- Clock and reset:
  - Only clk is used.
  - reset is sampled on the rising edge and overrides every other input.
- Reset values:
  - count_out = 0, wrap = 0.
  - Prescaler = 0, scan timer = 0, digit index = 0.
  - fndCom = 4'b1110, fndFont = 8'hC0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run=1.
  - tick asserts for one cycle in the cycle where prescaler == TICK_DIV-1; the prescaler returns to 0 on the next edge.
  - run=0 holds the prescaler value.
- Counter, on each edge with run=1 and tick=1:
  - up_dn=1: count == MAX_COUNT → 0 with wrap=1; otherwise count+1.
  - up_dn=0: count == 0 → MAX_COUNT with wrap=1; otherwise count-1.
  - Otherwise count holds and wrap=0.
  - wrap is registered and coincides with the new count value.
- clear:
  - Next edge: count=0, prescaler=0, wrap=0.
  - Has priority over tick, and over run=0.
  - Display scan is unaffected.
- up_dn changes take effect on the next tick. No glitch or skip is allowed.
- Scan:
  - Scan timer counts 0..SCAN_DIV-1 continuously, independent of run and clear.
  - At terminal value the digit index advances 0→1→2→3→0.
- Digit values:
  - d0 = count%10, d1 = (count/10)%10, d2 = (count/100)%10, d3 = count/1000.
  - Computed combinationally from the registered count.
- Display registers:
  - fndCom and fndFont are registered, one-cycle latency from the digit index and count.
  - fndCom = ~(4'b0001 << index).
- Font (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Blanking:
  - With BLANK_LZ=1, digit k (k ≥ 1) shows 8'hFF when it and all higher digits are zero.
  - Example: count 7 → d3..d1 blank.
  - With BLANK_LZ=0 all digits are always shown.
- Paused indicator:
  - When run=0, the dp bit is driven low (lit) while index=0.
  - Applies from the first post-reset display update.
- Reset mid-operation: all state returns to reset values on the same edge. There is no partial-state retention.

Test Plan:
- TICK_DIV=4, MAX_COUNT=9999, run=1, up_dn=1:
  - Stimulus: hold 12 cycles after reset release.
  - Required: count_out steps 0→1→2→3, each step exactly 4 cycles apart; wrap stays 0.
- MAX_COUNT=12, count up:
  - Stimulus: run until the terminal value.
  - Required: 12→0 with a single-cycle wrap=1. Then set up_dn=0; required: 0→12 with wrap=1 at the next tick.
- clear while run=1:
  - Stimulus: assert clear at count=5, in the same cycle as a tick.
  - Required: count_out=0, wrap=0, prescaler restarts; the next increment comes TICK_DIV cycles after clear deasserts.
- SCAN_DIV=2, count=1204, BLANK_LZ=1:
  - Required: fndCom cycles E,D,B,7 every 2 cycles.
  - Required: fndFont = 99, C0, A4, F9 respectively, each one cycle after its index.
- count=7, BLANK_LZ=1, run=0:
  - Required: digit0 shows 8'h78 (7 with dp lit); digits 1–3 show FF.
  - Required: count_out stays frozen for ≥ 3·TICK_DIV cycles.
- Reset mid-count:
  - Stimulus: assert reset at count=37, index=2.
  - Required: next edge count_out=0, fndCom=E, fndFont=C0, wrap=0.
